// File: rtl/estagio_writeback_pkg.sv
// Shared definitions for the writeback stage: widths, load funct3 codes and ALU result payload.
package estagio_writeback_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned F3_W     = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // One buffered ALU result: destination register and value.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  dado;
  } ula_res_t;

endpackage

// File: rtl/estagio_writeback_fila_resultados_ula.sv
// Small circular FIFO holding ALU results that could not retire immediately.
module fila_resultados_ula
  import estagio_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  ula_res_t dado_i,
  input  logic     pop_i,
  output ula_res_t dado_o,
  output logic     cheia_o,
  output logic     vazia_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ula_res_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cheia_o = (cnt_q == CNT_W'(DEPTH));
  assign vazia_o = (cnt_q == '0);
  assign push_ok = push_i && !cheia_o;
  assign pop_ok  = pop_i && !vazia_o;
  assign dado_o  = mem_q[rd_ptr_q];

  // Storage: written at the tail on every accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= dado_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= avanca(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= avanca(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/estagio_writeback.sv
// Writeback stage: arbitrates loads, buffered and direct ALU results onto the
// single register bank write port and tracks outstanding destination registers.
module estagio_writeback
  import estagio_writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ula_valido,
  output logic                ula_pronto,
  input  logic [REG_W-1:0]    ula_rd,
  input  logic [XLEN-1:0]     ula_dado,
  input  logic                mem_valido,
  input  logic [REG_W-1:0]    mem_rd,
  input  logic [XLEN-1:0]     mem_dado,
  input  logic [F3_W-1:0]     mem_funct3,
  input  logic [1:0]          mem_offset,
  input  logic                reserva_valido,
  input  logic [REG_W-1:0]    reserva_rd,
  output logic [NUM_REGS-1:0] pendente,
  output logic                escrever_registrador,
  output logic [REG_W-1:0]    registrador_escrita,
  output logic [XLEN-1:0]     dados_escrita,
  output logic                erro_carga
);

  ula_res_t            fifo_in, fifo_head;
  logic                fifo_push, fifo_pop, fifo_cheia, fifo_vazia;
  logic                ula_aceito;

  logic                sel_valido, sel_erro, escreve_d;
  logic [REG_W-1:0]    sel_rd;
  logic [XLEN-1:0]     sel_dado;

  logic                we_q, erro_q;
  logic [REG_W-1:0]    addr_q;
  logic [XLEN-1:0]     data_q;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  function automatic logic carga_legal(input logic [F3_W-1:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  // Extracts and extends the addressed byte/half from the aligned word.
  function automatic logic [XLEN-1:0] formatar_carga(input logic [F3_W-1:0] f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   return {{(XLEN-8){b[7]}}, b};
      F3_LH:   return {{(XLEN-16){h[15]}}, h};
      F3_LW:   return w;
      F3_LBU:  return {{(XLEN-8){1'b0}}, b};
      F3_LHU:  return {{(XLEN-16){1'b0}}, h};
      default: return '0;
    endcase
  endfunction

  fila_resultados_ula #(.DEPTH(FIFO_DEPTH)) u_fila (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .dado_i  (fifo_in),
    .pop_i   (fifo_pop),
    .dado_o  (fifo_head),
    .cheia_o (fifo_cheia),
    .vazia_o (fifo_vazia)
  );

  // Ready depends only on occupancy; a same-cycle pop does not grant a slot.
  assign ula_pronto = !reset && !fifo_cheia;
  assign ula_aceito = ula_valido && ula_pronto;
  assign fifo_in    = '{rd: ula_rd, dado: ula_dado};

  // Source selection: load first, then FIFO head, then direct ALU when FIFO empty.
  always_comb begin
    sel_valido = 1'b0;
    sel_erro   = 1'b0;
    sel_rd     = '0;
    sel_dado   = '0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (mem_valido) begin
      sel_rd    = mem_rd;
      fifo_push = ula_aceito;
      if (carga_legal(mem_funct3)) begin
        sel_valido = 1'b1;
        sel_dado   = formatar_carga(mem_funct3, mem_offset, mem_dado);
      end else begin
        sel_erro = 1'b1;
      end
    end else if (!fifo_vazia) begin
      fifo_pop   = 1'b1;
      fifo_push  = ula_aceito;
      sel_valido = 1'b1;
      sel_rd     = fifo_head.rd;
      sel_dado   = fifo_head.dado;
    end else if (ula_aceito) begin
      sel_valido = 1'b1;
      sel_rd     = ula_rd;
      sel_dado   = ula_dado;
    end
  end

  assign escreve_d = sel_valido && (sel_rd != '0);

  // Scoreboard update: retire clears, reservation sets and wins on collision.
  always_comb begin
    pend_d = pend_q;
    if (escreve_d) pend_d[sel_rd] = 1'b0;
    if (reserva_valido && (reserva_rd != '0)) pend_d[reserva_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      erro_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      we_q   <= escreve_d;
      erro_q <= sel_erro;
      pend_q <= pend_d;
      if (escreve_d) begin
        addr_q <= sel_rd;
        data_q <= sel_dado;
      end
    end
  end

  assign escrever_registrador = we_q;
  assign registrador_escrita  = addr_q;
  assign dados_escrita        = data_q;
  assign erro_carga           = erro_q;
  assign pendente             = pend_q;

endmodule

// File: tb/tb_estagio_writeback.sv
// Directed bench for estagio_writeback with a queue-based reference model.
module tb_estagio_writeback;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ula_valido, ula_pronto;
  logic [4:0]  ula_rd;
  logic [31:0] ula_dado;
  logic        mem_valido;
  logic [4:0]  mem_rd;
  logic [31:0] mem_dado;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic        reserva_valido;
  logic [4:0]  reserva_rd;
  logic [31:0] pendente;
  logic        escrever_registrador;
  logic [4:0]  registrador_escrita;
  logic [31:0] dados_escrita;
  logic        erro_carga;

  int total = 0;
  int bad   = 0;

  estagio_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ula_valido           (ula_valido),
    .ula_pronto           (ula_pronto),
    .ula_rd               (ula_rd),
    .ula_dado             (ula_dado),
    .mem_valido           (mem_valido),
    .mem_rd               (mem_rd),
    .mem_dado             (mem_dado),
    .mem_funct3           (mem_funct3),
    .mem_offset           (mem_offset),
    .reserva_valido       (reserva_valido),
    .reserva_rd           (reserva_rd),
    .pendente             (pendente),
    .escrever_registrador (escrever_registrador),
    .registrador_escrita  (registrador_escrita),
    .dados_escrita        (dados_escrita),
    .erro_carga           (erro_carga)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending ALU results, pending bit vector.
  logic [4:0]  qrd[$];
  logic [31:0] qd[$];
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0, pend_m = '0;
  logic        m_acc, m_have;
  logic [4:0]  m_r;
  logic [31:0] m_d;

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (off * 8)) & 32'hFF;
    h = (w >> (off[1] * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      default: return h;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qrd.delete(); qd.delete();
      m_we = 0; m_err = 0; m_addr = 0; m_data = 0; pend_m = 0;
    end else begin
      m_acc  = ula_valido && (qd.size() < DEPTH);
      m_we   = 0;
      m_err  = 0;
      m_have = 0;
      m_r    = 0;
      m_d    = 0;
      if (mem_valido) begin
        if (legal(mem_funct3)) begin
          m_have = 1; m_r = mem_rd; m_d = fmt(mem_funct3, mem_offset, mem_dado);
        end else m_err = 1;
        if (m_acc) begin qrd.push_back(ula_rd); qd.push_back(ula_dado); end
      end else if (qd.size() > 0) begin
        m_have = 1; m_r = qrd.pop_front(); m_d = qd.pop_front();
        if (m_acc) begin qrd.push_back(ula_rd); qd.push_back(ula_dado); end
      end else if (m_acc) begin
        m_have = 1; m_r = ula_rd; m_d = ula_dado;
      end
      if (m_have && m_r != 0) begin
        m_we = 1; m_addr = m_r; m_data = m_d; pend_m[m_r] = 0;
      end
      if (reserva_valido && reserva_rd != 0) pend_m[reserva_rd] = 1;
    end
  end

  // Every falling edge the DUT outputs must match the model.
  always @(negedge clk) begin
    cmp("m_we",      32'(escrever_registrador), 32'(m_we));
    cmp("m_addr",    32'(registrador_escrita),  32'(m_addr));
    cmp("m_data",    dados_escrita,             m_data);
    cmp("m_err",     32'(erro_carga),           32'(m_err));
    cmp("m_pend",    pendente,                  pend_m);
    cmp("m_pronto",  32'(ula_pronto),           32'(!reset && qd.size() < DEPTH));
  end

  task automatic clr();
    ula_valido = 0; ula_rd = 0; ula_dado = 0;
    mem_valido = 0; mem_rd = 0; mem_dado = 0; mem_funct3 = 0; mem_offset = 0;
    reserva_valido = 0; reserva_rd = 0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
    ula_valido = 1; ula_rd = rd; ula_dado = d;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    mem_valido = 1; mem_rd = rd; mem_funct3 = f3; mem_offset = off; mem_dado = w;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1;
    tick(); tick();
    cmp("rst_we",     32'(escrever_registrador), 0);
    cmp("rst_addr",   32'(registrador_escrita), 0);
    cmp("rst_data",   dados_escrita, 0);
    cmp("rst_pend",   pendente, 0);
    cmp("rst_pronto", 32'(ula_pronto), 0);
    cmp("rst_err",    32'(erro_carga), 0);
    reset = 0;

    // Lone ALU write
    set_alu(5, 32'h1234);
    #1 cmp("alu_pronto_pre", 32'(ula_pronto), 1);
    tick(); clr();
    cmp("alu_we",   32'(escrever_registrador), 1);
    cmp("alu_addr", 32'(registrador_escrita), 5);
    cmp("alu_data", dados_escrita, 32'h00001234);
    cmp("alu_pronto", 32'(ula_pronto), 1);

    // Load formatting
    set_mem(7, 3'b000, 2'd1, 32'h80FF7F01); tick();
    cmp("lb1_addr", 32'(registrador_escrita), 7);
    cmp("lb1", dados_escrita, 32'h0000007F);
    set_mem(7, 3'b000, 2'd2, 32'h80FF7F01); tick();
    cmp("lb2", dados_escrita, 32'hFFFFFFFF);
    set_mem(7, 3'b101, 2'd2, 32'h80FF7F01); tick();
    cmp("lhu2", dados_escrita, 32'h000080FF);
    set_mem(8, 3'b001, 2'd2, 32'h80FF7F01); tick();
    cmp("lh2", dados_escrita, 32'hFFFF80FF);
    set_mem(8, 3'b010, 2'd3, 32'h80FF7F01); tick();
    cmp("lw3", dados_escrita, 32'h80FF7F01);
    set_mem(8, 3'b100, 2'd3, 32'h80FF7F01); tick();
    cmp("lbu3", dados_escrita, 32'h00000080);
    clr(); tick();
    cmp("idle_we",   32'(escrever_registrador), 0);
    cmp("idle_hold", dados_escrita, 32'h00000080);

    // Loads and ALU together: loads first, ALU buffered then drained in order
    set_mem(10, 3'b010, 0, 32'hA); set_alu(11, 32'hB); tick();
    cmp("cf_a_addr", 32'(registrador_escrita), 10);
    cmp("cf_a_pronto", 32'(ula_pronto), 1);
    set_mem(12, 3'b010, 0, 32'hC); set_alu(13, 32'hD); tick();
    cmp("cf_b_addr", 32'(registrador_escrita), 12);
    cmp("cf_b_pronto", 32'(ula_pronto), 0);
    set_mem(14, 3'b010, 0, 32'hE); set_alu(15, 32'hF); tick();
    cmp("cf_c_addr", 32'(registrador_escrita), 14);
    cmp("cf_c_pronto", 32'(ula_pronto), 0);
    mem_valido = 0; tick();
    cmp("cf_d_addr", 32'(registrador_escrita), 11);
    cmp("cf_d_data", dados_escrita, 32'hB);
    cmp("cf_d_pronto", 32'(ula_pronto), 1);
    tick(); ula_valido = 0;
    cmp("cf_e_addr", 32'(registrador_escrita), 13);
    cmp("cf_e_data", dados_escrita, 32'hD);
    tick();
    cmp("cf_f_addr", 32'(registrador_escrita), 15);
    cmp("cf_f_data", dados_escrita, 32'hF);
    tick();
    cmp("cf_g_we", 32'(escrever_registrador), 0);

    // Scoreboard
    reserva_valido = 1; reserva_rd = 9; tick(); clr();
    cmp("sb_set", 32'(pendente[9]), 1);
    set_alu(9, 32'h99); tick(); clr();
    cmp("sb_clr", 32'(pendente[9]), 0);
    cmp("sb_clr_we", 32'(escrever_registrador), 1);
    reserva_valido = 1; reserva_rd = 9; tick();
    set_alu(9, 32'h77); tick(); clr();
    cmp("sb_both", 32'(pendente[9]), 1);
    cmp("sb_both_addr", 32'(registrador_escrita), 9);
    reserva_valido = 1; reserva_rd = 0; tick(); clr();
    cmp("sb_x0", 32'(pendente[0]), 0);

    // rd=0 from both sources never writes
    set_mem(0, 3'b010, 0, 32'h5555); set_alu(0, 32'h6666); tick(); clr();
    cmp("rd0_mem_we", 32'(escrever_registrador), 0);
    tick();
    cmp("rd0_alu_we", 32'(escrever_registrador), 0);

    // Illegal funct3
    reserva_valido = 1; reserva_rd = 20; tick(); clr();
    set_mem(20, 3'b011, 0, 32'h1111); tick(); clr();
    cmp("ill_err", 32'(erro_carga), 1);
    cmp("ill_we", 32'(escrever_registrador), 0);
    cmp("ill_pend", 32'(pendente[20]), 1);
    tick();
    cmp("ill_err_off", 32'(erro_carga), 0);

    // Reset with two buffered entries
    set_mem(21, 3'b010, 0, 32'h21); set_alu(22, 32'h22); tick();
    set_mem(23, 3'b010, 0, 32'h23); set_alu(24, 32'h24); tick();
    clr();
    cmp("pre_rst_pronto", 32'(ula_pronto), 0);
    #2 reset = 1;
    #1;
    cmp("arst_we",     32'(escrever_registrador), 0);
    cmp("arst_addr",   32'(registrador_escrita), 0);
    cmp("arst_data",   dados_escrita, 0);
    cmp("arst_pend",   pendente, 0);
    cmp("arst_pronto", 32'(ula_pronto), 0);
    tick(); reset = 0;
    tick(); cmp("post_rst_we1", 32'(escrever_registrador), 0);
    tick(); cmp("post_rst_we2", 32'(escrever_registrador), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
